// File: rtl/spi_csr_bridge_if.sv
// CSR-side bus between spi_csr_bridge (master) and the CSR register map (slave).
interface spi_csr_bridge_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] addr_o;
    logic [DATA_WIDTH-1:0] write_data_o;
    logic                  write_en_o;
    logic                  read_en_o;
    logic [DATA_WIDTH-1:0] read_data_i;

    modport master (
        output addr_o, write_data_o, write_en_o, read_en_o,
        input  read_data_i
    );

    modport slave (
        input  addr_o, write_data_o, write_en_o, read_en_o,
        output read_data_i
    );
endinterface

// File: rtl/spi_csr_bridge.sv
// SPI mode-0 slave that turns command frames into held CSR read/write accesses.
// Define SPI_CSR_AUTO_INC_EN for burst frames with address auto-increment.
module spi_csr_bridge #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             rstn_n,
    input  logic             sclk_i,
    input  logic             csn_i,
    input  logic             mosi_i,
    output logic             miso_o,
    output logic             miso_oe_o,
    output logic             busy_o,
    spi_csr_bridge_if.master csr
);
    localparam int CMD_WIDTH      = ADDR_WIDTH + 1;
    localparam int RX_WIDTH       = (CMD_WIDTH > DATA_WIDTH) ? CMD_WIDTH : DATA_WIDTH;
    localparam int BIT_CNT_WIDTH  = $clog2(RX_WIDTH + 1);
    localparam int HOLD_CNT_WIDTH = $clog2(HOLD_CYCLES + 1);

    localparam logic [BIT_CNT_WIDTH-1:0]  LAST_CMD_BIT  = BIT_CNT_WIDTH'(CMD_WIDTH - 1);
    localparam logic [BIT_CNT_WIDTH-1:0]  LAST_DATA_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [HOLD_CNT_WIDTH-1:0] LAST_HOLD     = HOLD_CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [HOLD_CNT_WIDTH-1:0] CAPTURE_SLOT  = HOLD_CNT_WIDTH'(HOLD_CYCLES);

    typedef enum logic [2:0] {IDLE, CMD, RD_REQ, DATA, WR_REQ, DONE} state_t;

    state_t                     state;
    logic                       sclk_meta, sclk_sync, sclk_prev;
    logic                       csn_meta, csn_sync, csn_prev;
    logic                       mosi_meta, mosi_sync;
    logic [RX_WIDTH-2:0]        rx_shift;
    logic [RX_WIDTH-1:0]        rx_next;
    logic [DATA_WIDTH-1:0]      tx_shift;
    logic [BIT_CNT_WIDTH-1:0]   bit_cnt;
    logic [HOLD_CNT_WIDTH-1:0]  hold_cnt;
    logic                       is_read;
    logic [ADDR_WIDTH-1:0]      addr_q;
    logic [DATA_WIDTH-1:0]      wdata_q;
    logic                       we_q, re_q, miso_q, miso_oe_q, busy_q;
    logic                       sclk_rise, sclk_fall, csn_fall;

    // Two-flop synchronisers, plus one extra stage on sclk/csn for edge detection.
    always_ff @(posedge clk_i or negedge rstn_n) begin
        if (!rstn_n) begin
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_prev <= 1'b0;
            csn_meta  <= 1'b1;
            csn_sync  <= 1'b1;
            csn_prev  <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            sclk_meta <= sclk_i;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            csn_meta  <= csn_i;
            csn_sync  <= csn_meta;
            csn_prev  <= csn_sync;
            mosi_meta <= mosi_i;
            mosi_sync <= mosi_meta;
        end
    end

    assign sclk_rise = sclk_sync & ~sclk_prev;
    assign sclk_fall = ~sclk_sync & sclk_prev;
    assign csn_fall  = ~csn_sync & csn_prev;
    assign rx_next   = {rx_shift, mosi_sync};

    always_ff @(posedge clk_i or negedge rstn_n) begin
        if (!rstn_n) begin
            state     <= IDLE;
            rx_shift  <= '0;
            tx_shift  <= '0;
            bit_cnt   <= '0;
            hold_cnt  <= '0;
            is_read   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    miso_q    <= 1'b0;
                    miso_oe_q <= 1'b0;
                    busy_q    <= 1'b0;
                    if (csn_fall) begin
                        state     <= CMD;
                        bit_cnt   <= '0;
                        miso_oe_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end

                CMD: begin
                    if (csn_sync) begin
                        state     <= IDLE;
                        miso_q    <= 1'b0;
                        miso_oe_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_shift <= rx_next[RX_WIDTH-2:0];
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_CMD_BIT) begin
                            addr_q   <= rx_next[ADDR_WIDTH-1:0];
                            is_read  <= rx_next[ADDR_WIDTH];
                            bit_cnt  <= '0;
                            hold_cnt <= '0;
                            tx_shift <= '0;
                            if (rx_next[ADDR_WIDTH]) begin
                                state <= RD_REQ;
                                re_q  <= 1'b1;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                end

                // Enable held HOLD_CYCLES clocks; the map's data is captured one clock later.
                RD_REQ: begin
                    miso_oe_q <= ~csn_sync;
                    hold_cnt  <= hold_cnt + 1'b1;
                    if (hold_cnt == LAST_HOLD) begin
                        re_q <= 1'b0;
                    end
                    if (hold_cnt == CAPTURE_SLOT) begin
                        tx_shift <= csr.read_data_i;
                        bit_cnt  <= '0;
                        hold_cnt <= '0;
                        if (csn_sync) begin
                            state     <= IDLE;
                            miso_q    <= 1'b0;
                            miso_oe_q <= 1'b0;
                            busy_q    <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (csn_sync) begin
                        state     <= IDLE;
                        miso_q    <= 1'b0;
                        miso_oe_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else begin
                        if (sclk_fall) begin
                            miso_q   <= is_read & tx_shift[DATA_WIDTH-1];
                            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            rx_shift <= rx_next[RX_WIDTH-2:0];
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_DATA_BIT) begin
                                bit_cnt  <= '0;
                                hold_cnt <= '0;
                                if (is_read) begin
`ifdef SPI_CSR_AUTO_INC_EN
                                    addr_q <= addr_q + 1'b1;
                                    re_q   <= 1'b1;
                                    state  <= RD_REQ;
`else
                                    state  <= DONE;
`endif
                                end else begin
                                    wdata_q <= rx_next[DATA_WIDTH-1:0];
                                    we_q    <= 1'b1;
                                    state   <= WR_REQ;
                                end
                            end
                        end
                    end
                end

                // A started write always runs its full hold, even if csn has already risen.
                WR_REQ: begin
                    miso_oe_q <= ~csn_sync;
                    hold_cnt  <= hold_cnt + 1'b1;
                    if (hold_cnt == LAST_HOLD) begin
                        we_q     <= 1'b0;
                        hold_cnt <= '0;
                        if (csn_sync) begin
                            state     <= IDLE;
                            miso_q    <= 1'b0;
                            miso_oe_q <= 1'b0;
                            busy_q    <= 1'b0;
                        end else begin
`ifdef SPI_CSR_AUTO_INC_EN
                            addr_q <= addr_q + 1'b1;
                            state  <= DATA;
`else
                            state  <= DONE;
`endif
                        end
                    end
                end

                DONE: begin
                    if (csn_sync) begin
                        state     <= IDLE;
                        miso_q    <= 1'b0;
                        miso_oe_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign csr.addr_o       = addr_q;
    assign csr.write_data_o = wdata_q;
    assign csr.write_en_o   = we_q;
    assign csr.read_en_o    = re_q;
    assign miso_o           = miso_q;
    assign miso_oe_o        = miso_oe_q;
    assign busy_o           = busy_q;
endmodule

// File: tb/tb_spi_csr_bridge.sv
// Directed and randomized frames against spi_csr_bridge with a behavioural CSR map attached.
module tb_spi_csr_bridge;
    localparam int AW       = 7;
    localparam int DW       = 8;
    localparam int HOLD     = 4;
    localparam int HALF     = 10;
    localparam int MAP_SIZE = 64;

    logic clk = 1'b0;
    logic rstn_n, sclk, csn, mosi, map_ready;
    logic miso, miso_oe, busy;

    always #5 clk = ~clk;

    spi_csr_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) csr_bus ();

    spi_csr_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HOLD_CYCLES(HOLD)) dut (
        .clk_i     (clk),
        .rstn_n    (rstn_n),
        .sclk_i    (sclk),
        .csn_i     (csn),
        .mosi_i    (mosi),
        .miso_o    (miso),
        .miso_oe_o (miso_oe),
        .busy_o    (busy),
        .csr       (csr_bus)
    );

    // Register map stand-in: 64 registers, two-stage read pipe, 0xFF beyond the map.
    logic [7:0] map_mem [MAP_SIZE];
    logic [7:0] rd_stage1, rd_stage2;
    always @(posedge clk) begin
        if (!map_ready) begin
            for (int i = 0; i < MAP_SIZE; i++) map_mem[i] <= 8'h00;
            map_mem[0] <= 8'hCC;
            rd_stage1  <= 8'hFF;
            rd_stage2  <= 8'hFF;
        end else begin
            if (csr_bus.write_en_o && csr_bus.addr_o < MAP_SIZE)
                map_mem[csr_bus.addr_o[5:0]] <= csr_bus.write_data_o;
            rd_stage1 <= (csr_bus.addr_o < MAP_SIZE) ? map_mem[csr_bus.addr_o[5:0]] : 8'hFF;
            rd_stage2 <= rd_stage1;
        end
    end
    assign csr_bus.read_data_i = rd_stage2;

    // Access monitor: each enable pulse becomes one record with its length and stability.
    typedef struct {
        bit is_wr;
        int addr;
        int data;
        int len;
        bit stable;
    } access_t;

    access_t seen[$];
    access_t cur;
    bit      in_pulse = 1'b0;
    int      overlap  = 0;

    always @(negedge clk) begin
        if (!rstn_n) begin
            in_pulse = 1'b0;
        end else if (csr_bus.write_en_o || csr_bus.read_en_o) begin
            if (csr_bus.write_en_o && csr_bus.read_en_o) overlap++;
            if (!in_pulse) begin
                cur.is_wr  = csr_bus.write_en_o;
                cur.addr   = int'(csr_bus.addr_o);
                cur.data   = int'(csr_bus.write_data_o);
                cur.len    = 1;
                cur.stable = 1'b1;
                in_pulse   = 1'b1;
            end else begin
                cur.len++;
                if (cur.addr != int'(csr_bus.addr_o) || cur.data != int'(csr_bus.write_data_o) ||
                    cur.is_wr != csr_bus.write_en_o)
                    cur.stable = 1'b0;
            end
        end else if (in_pulse) begin
            seen.push_back(cur);
            in_pulse = 1'b0;
        end
    end

    int ref_mem [MAP_SIZE];
    int checks   = 0;
    int failures = 0;

    function automatic int ref_read(input int a);
        return (a < MAP_SIZE) ? ref_mem[a] : 'hFF;
    endfunction

    function automatic void ref_write(input int a, input int d);
        if (a < MAP_SIZE) ref_mem[a] = d;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_start();
        sclk = 1'b0;
        csn  = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic spi_bit(input logic b, output logic m);
        if (sclk) begin
            wait_clk(HALF);
            sclk = 1'b0;
        end
        mosi = b;
        wait_clk(HALF);
        m    = miso;
        sclk = 1'b1;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic m;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], m);
            rx[i] = m;
        end
    endtask

    task automatic spi_end(input int delay);
        wait_clk(delay);
        sclk = 1'b0;
        csn  = 1'b1;
        mosi = 1'b0;
        wait_clk(3 * HALF);
    endtask

    task automatic do_write(input int a, input int d);
        logic [7:0] rx;
        spi_start();
        spi_byte({1'b0, a[6:0]}, rx);
        spi_byte(d[7:0], rx);
        spi_end(HALF);
        ref_write(a, d);
    endtask

    task automatic do_read(input int a, output logic [7:0] data);
        logic [7:0] rx;
        spi_start();
        spi_byte({1'b1, a[6:0]}, rx);
        spi_byte(8'h00, data);
        spi_end(HALF);
    endtask

    task automatic expect_access(input string tag, input bit is_wr, input int a, input int d,
                                 input bit last);
        access_t acc;
        check_output({tag, "_present"}, (seen.size() > 0) ? 1 : 0, 1);
        if (seen.size() > 0) begin
            acc = seen.pop_front();
            check_output({tag, "_kind"}, acc.is_wr, is_wr);
            check_output({tag, "_addr"}, acc.addr, a);
            if (is_wr) check_output({tag, "_data"}, acc.data, d);
            check_output({tag, "_len"}, acc.len, HOLD);
            check_output({tag, "_stable"}, acc.stable, 1);
        end
        if (last) begin
            check_output({tag, "_extra"}, seen.size(), 0);
            seen.delete();
        end
    endtask

    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] rd;
        logic       m;
        int         a, d;

        rstn_n = 1'b0; sclk = 1'b0; csn = 1'b1; mosi = 1'b0; map_ready = 1'b0;
        for (int i = 0; i < MAP_SIZE; i++) ref_mem[i] = 0;
        ref_mem[0] = 'hCC;
        wait_clk(4);
        map_ready = 1'b1;
        wait_clk(2);
        rstn_n = 1'b1;
        wait_clk(4);

        check_output("rst_addr", csr_bus.addr_o, 0);
        check_output("rst_wdata", csr_bus.write_data_o, 0);
        check_output("rst_we", csr_bus.write_en_o, 0);
        check_output("rst_re", csr_bus.read_en_o, 0);
        check_output("rst_miso", miso, 0);
        check_output("rst_oe", miso_oe, 0);
        check_output("rst_busy", busy, 0);

        do_read(0, rd);
        check_output("rd0_data", rd, ref_read(0));
        expect_access("rd0", 1'b0, 0, 0, 1'b1);

        do_write('h05, 'hA5);
        expect_access("wr5", 1'b1, 'h05, 'hA5, 1'b1);
        do_read('h05, rd);
        check_output("rd5_data", rd, ref_read('h05));
        expect_access("rd5", 1'b0, 'h05, 0, 1'b1);

        do_read('h70, rd);
        check_output("rd_oor_data", rd, ref_read('h70));
        expect_access("rd_oor", 1'b0, 'h70, 0, 1'b1);

        // Chip select dropped after five data bits: the partial word must be discarded.
        spi_start();
        spi_byte(8'h0A, rd);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, m);
        check_output("abort_busy_mid", busy, 1);
        check_output("abort_oe_mid", miso_oe, 1);
        spi_end(HALF);
        check_output("abort_busy_after", busy, 0);
        check_output("abort_oe_after", miso_oe, 0);
        check_output("abort_no_access", seen.size(), 0);
        do_read('h0A, rd);
        check_output("abort_readback", rd, ref_read('h0A));
        expect_access("abort_rd", 1'b0, 'h0A, 0, 1'b1);

        // Chip select rises while the write enable is already held.
        spi_start();
        spi_byte(8'h0B, rd);
        spi_byte(8'h3C, rd);
        spi_end(4);
        ref_write('h0B, 'h3C);
        expect_access("wr_csn", 1'b1, 'h0B, 'h3C, 1'b1);
        check_output("wr_csn_busy", busy, 0);

        // Reset pulsed in the middle of a write enable.
        spi_start();
        spi_byte(8'h0C, rd);
        spi_byte(8'h77, rd);
        wait_clk(5);
        check_output("rstmid_we_before", csr_bus.write_en_o, 1);
        rstn_n = 1'b0;
        #1;
        check_output("rstmid_we", csr_bus.write_en_o, 0);
        check_output("rstmid_re", csr_bus.read_en_o, 0);
        check_output("rstmid_addr", csr_bus.addr_o, 0);
        check_output("rstmid_wdata", csr_bus.write_data_o, 0);
        check_output("rstmid_miso", miso, 0);
        check_output("rstmid_oe", miso_oe, 0);
        check_output("rstmid_busy", busy, 0);
        ref_write('h0C, 'h77);
        sclk = 1'b0;
        csn  = 1'b1;
        wait_clk(3);
        rstn_n = 1'b1;
        wait_clk(10);
        check_output("rstmid_no_access", seen.size(), 0);
        do_write('h12, 'h5A);
        expect_access("post_rst_wr", 1'b1, 'h12, 'h5A, 1'b1);
        do_read('h12, rd);
        check_output("post_rst_rd", rd, ref_read('h12));
        expect_access("post_rst_rdacc", 1'b0, 'h12, 0, 1'b1);

        for (int k = 0; k < 6; k++) begin
            a = int'($urandom_range(0, 127));
            d = int'($urandom_range(0, 255));
            do_write(a, d);
            expect_access("rnd_wr", 1'b1, a, d, 1'b1);
            if (k % 2 == 1) a = int'($urandom_range(0, 127));
            do_read(a, rd);
            check_output("rnd_rd_data", rd, ref_read(a));
            expect_access("rnd_rd", 1'b0, a, 0, 1'b1);
        end

        // Multi-word write frame starting at the top address.
        spi_start();
        spi_byte(8'h7F, rd);
        spi_byte(8'h11, rd);
        spi_byte(8'h22, rd);
        spi_end(HALF);
`ifdef SPI_CSR_AUTO_INC_EN
        ref_write('h7F, 'h11);
        ref_write('h00, 'h22);
        expect_access("burst0", 1'b1, 'h7F, 'h11, 1'b0);
        expect_access("burst1", 1'b1, 'h00, 'h22, 1'b1);
`else
        ref_write('h7F, 'h11);
        expect_access("single", 1'b1, 'h7F, 'h11, 1'b1);
`endif
        do_read(0, rd);
        check_output("burst_rd0", rd, ref_read(0));
        expect_access("burst_rdacc", 1'b0, 0, 0, 1'b1);

        check_output("no_overlap", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
